// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: sequences control-flow redirects from decode to fetch.
// Accepts one branch/jump request at a time, computes the target and presents it
// to fetch with a valid/ack handshake. It then holds flush for FLUSH_CYCLES cycles
// and discards the wrong-path requests that arrive during that window.
// Optional feature macro: FETCH_REDIRECT_LINK_EN adds link-address generation for
// kinds 2 and 3. Without it link_valid/link_addr are tied to 0.
// PC_W must be larger than OFF_W.
module fetch_redirect_ctrl #(
    parameter int unsigned PC_W         = 20,
    parameter int unsigned OFF_W        = 9,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [PC_W-1:0] req_pc,
    input  logic [OFF_W-1:0] req_offset,
    input  logic [PC_W-1:0] req_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ack,
    output logic            flush,
    output logic            link_valid,
    output logic [PC_W-1:0] link_addr,
    output logic [7:0]      drop_count,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            rv_q, rv_d;
    logic            flush_q, flush_d;
    logic [7:0]      drop_q, drop_d;

    logic            accept;
    logic            is_rel;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] tgt;

    // Only IDLE accepts for real; FLUSH also shows ready so wrong-path requests drain.
    assign req_ready = (state_q != StRedirect);
    assign busy      = (state_q != StIdle);
    assign accept    = req_valid && (state_q == StIdle);

    // Kinds 0 and 3 are PC-relative, kinds 1 and 2 absolute.
    assign is_rel  = (req_kind[1] == req_kind[0]);
    assign off_ext = {{(PC_W - OFF_W){req_offset[OFF_W-1]}}, req_offset};
    assign tgt     = is_rel ? (req_pc + off_ext) : req_target;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        rv_d    = rv_q;
        flush_d = flush_q;
        drop_d  = drop_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    pc_d    = tgt;
                    rv_d    = 1'b1;
                    flush_d = 1'b1;
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ack) begin
                    rv_d    = 1'b0;
                    cnt_d   = FlushLoad;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (req_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                cnt_d = cnt_q - 4'd1;
                // Counter hits zero on this edge: leave FLUSH now.
                if (cnt_q == 4'd1) begin
                    flush_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                rv_d    = 1'b0;
                flush_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rv_q    <= rv_d;
            flush_q <= flush_d;
            drop_q  <= drop_d;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = pc_q;
    assign flush          = flush_q;
    assign drop_count     = drop_q;

`ifdef FETCH_REDIRECT_LINK_EN
    logic            is_link;
    logic            link_valid_q;
    logic [PC_W-1:0] link_addr_q;

    assign is_link = req_kind[1];

    // Link pulse lasts exactly the first REDIRECT cycle; the address is held after.
    always_ff @(posedge clock) begin
        if (reset) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= accept && is_link;
            if (accept && is_link) begin
                link_addr_q <= req_pc + PC_W'(1);
            end
        end
    end

    assign link_valid = link_valid_q;
    assign link_addr  = link_addr_q;
`else
    assign link_valid = 1'b0;
    assign link_addr  = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: expected redirect and link values are queued when a
// request is driven and compared by negedge monitors when the DUT presents them.
module tb_fetch_redirect_ctrl;

    localparam int unsigned PC_W  = 20;
    localparam int unsigned OFF_W = 9;
    localparam int unsigned FLUSH = 2;
`ifdef FETCH_REDIRECT_LINK_EN
    localparam bit LinkEn = 1'b1;
`else
    localparam bit LinkEn = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_kind = 2'd0;
    logic [PC_W-1:0]  req_pc = '0;
    logic [OFF_W-1:0] req_offset = '0;
    logic [PC_W-1:0]  req_target = '0;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             redirect_ack = 1'b0;
    logic             flush;
    logic             link_valid;
    logic [PC_W-1:0]  link_addr;
    logic [7:0]       drop_count;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_drop = 0;
    logic [PC_W-1:0] exp_pc_q[$];
    logic [PC_W-1:0] exp_link_q[$];
    logic [PC_W-1:0] cur_pc = '0;
    logic rv_prev = 1'b0;

    fetch_redirect_ctrl #(
        .PC_W        (PC_W),
        .OFF_W       (OFF_W),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_kind      (req_kind),
        .req_pc        (req_pc),
        .req_offset    (req_offset),
        .req_target    (req_target),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ack  (redirect_ack),
        .flush         (flush),
        .link_valid    (link_valid),
        .link_addr     (link_addr),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Redirect scoreboard: compare on the first cycle redirect_valid is seen high.
    always @(negedge clock) begin
        if (redirect_valid === 1'b1 && rv_prev !== 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                check("unexpected_redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
            end else begin
                cur_pc = exp_pc_q.pop_front();
                check("redirect_pc", 32'(redirect_pc), 32'(cur_pc));
            end
        end
        rv_prev = redirect_valid;
    end

    // Link scoreboard: every high cycle of link_valid consumes one expected entry.
    always @(negedge clock) begin
        if (link_valid === 1'b1) begin
            if (exp_link_q.size() == 0) begin
                check("unexpected_link", 32'(link_addr), 32'hFFFF_FFFF);
            end else begin
                check("link_addr", 32'(link_addr), 32'(exp_link_q.pop_front()));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        @(negedge clock);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rv"}, 32'(redirect_valid), 32'd0);
        check({tag, "_rpc"}, 32'(redirect_pc), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_lv"}, 32'(link_valid), 32'd0);
        check({tag, "_laddr"}, 32'(link_addr), 32'd0);
        check({tag, "_drop"}, 32'(drop_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Drive one request while idle and check cycle N+1.
    task automatic do_req(input logic [1:0] kind, input logic [PC_W-1:0] pc,
                          input logic [OFF_W-1:0] off, input logic [PC_W-1:0] tgt);
        logic [PC_W-1:0] t;
        bit lnk;
        if (kind == 2'd0 || kind == 2'd3) begin
            t = PC_W'(int'(pc) + int'($signed(off)));
        end else begin
            t = tgt;
        end
        lnk = LinkEn && (kind == 2'd2 || kind == 2'd3);
        exp_pc_q.push_back(t);
        if (lnk) exp_link_q.push_back(PC_W'(int'(pc) + 1));
        cur_pc     = t;
        req_kind   = kind;
        req_pc     = pc;
        req_offset = off;
        req_target = tgt;
        req_valid  = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("n1_rv", 32'(redirect_valid), 32'd1);
        check("n1_flush", 32'(flush), 32'd1);
        check("n1_ready", 32'(req_ready), 32'd0);
        check("n1_link", 32'(link_valid), 32'(lnk));
    endtask

    // Hold ack low for dly cycles, ack, then walk FLUSH; drop_mask[i] raises req_valid
    // in flush cycle i.
    task automatic ack_and_flush(input int dly, input logic [FLUSH-1:0] drop_mask);
        for (int i = 0; i < dly; i++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            check("hold_rv", 32'(redirect_valid), 32'd1);
            check("hold_pc", 32'(redirect_pc), 32'(cur_pc));
            check("hold_flush", 32'(flush), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_link", 32'(link_valid), 32'd0);
        end
        redirect_ack = 1'b1;
        @(posedge clock);
        #1 redirect_ack = 1'b0;
        for (int i = 0; i < int'(FLUSH); i++) begin
            req_valid = drop_mask[i];
            req_pc    = PC_W'(32'h777 + i);
            if (drop_mask[i] && exp_drop < 255) exp_drop++;
            @(negedge clock);
            check("fl_flush", 32'(flush), 32'd1);
            check("fl_rv", 32'(redirect_valid), 32'd0);
            check("fl_ready", 32'(req_ready), 32'd1);
            check("fl_link", 32'(link_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clock);
        check("idle_flush", 32'(flush), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_drop", 32'(drop_count), 32'(exp_drop));
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_reset_vals("rst");

        // Relative branch backwards, immediate ack: flush spans 1 + FLUSH cycles.
        do_req(2'd0, 20'h00100, 9'h1FC, 20'h0);
        ack_and_flush(0, '0);

        // Relative wrap past the top of the address space.
        do_req(2'd0, 20'hFFFFE, 9'h005, 20'h0);
        ack_and_flush(1, '0);

        // Branch+link at the top PC: link address wraps to zero.
        do_req(2'd3, 20'hFFFFF, 9'h010, 20'h0);
        ack_and_flush(0, '0);

        // Jump+link with ack delayed 5 cycles.
        do_req(2'd2, 20'h00200, 9'h0, 20'h12345);
        ack_and_flush(5, '0);

        // Absolute jump, and kind 2 to 0x40 (link only when enabled).
        do_req(2'd1, 20'h00300, 9'h0, 20'hABCDE);
        ack_and_flush(2, '0);
        do_req(2'd2, 20'h00400, 9'h0, 20'h00040);
        ack_and_flush(0, '0);

        // Ack outside REDIRECT is ignored.
        redirect_ack = 1'b1;
        @(posedge clock);
        #1 redirect_ack = 1'b0;
        @(negedge clock);
        check("stray_ack_busy", 32'(busy), 32'd0);
        check("stray_ack_rv", 32'(redirect_valid), 32'd0);

        // Wrong-path drops: two in one flush, then one in the final flush cycle.
        do_req(2'd0, 20'h01000, 9'h004, 20'h0);
        ack_and_flush(0, 2'b11);
        do_req(2'd1, 20'h01000, 9'h0, 20'h02000);
        ack_and_flush(0, 2'b10);
        check("drop3", 32'(drop_count), 32'd3);

        // Reset while a redirect is pending.
        do_req(2'd1, 20'h03000, 9'h0, 20'h05555);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_drop = 0;
        check_reset_vals("rst_mid");
        do_req(2'd3, 20'h04000, 9'h1F0, 20'h0);
        ack_and_flush(1, '0);

        // 300 wrong-path requests saturate the drop counter.
        for (int i = 0; i < 150; i++) begin
            do_req(2'd0, PC_W'(32'h10000 + i), 9'h002, 20'h0);
            ack_and_flush(0, 2'b11);
        end
        check("drop_sat", 32'(drop_count), 32'd255);

        @(negedge clock);
        check("sb_pc_empty", 32'(exp_pc_q.size()), 32'd0);
        check("sb_link_empty", 32'(exp_link_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
